risc_sequencer: RTL and testbench
=================================

Name: risc_sequencer

Overview:
- Eight-phase instruction sequencer for the basic RISC core.
- Sits directly upstream of the program counter and drives its enable and load controls.
- Also drives the instruction register, accumulator, memory read/write and the address mux select.
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag, one phase per clock.

Parameters:
- None. Opcode width (3) and phase count (8) are fixed by risc_pkg.

Ports:
- CLK    in   1  system clock; all state updates on rising edge
- RST    in   1  synchronous reset, active-high
- OPCODE in   3  opcode field from instruction register (risc_pkg::opcode_t)
- ZERO   in   1  accumulator == 0 flag
- SEL    out  1  address mux: 1 = PC, 0 = IR operand
- RD     out  1  memory read strobe
- WR     out  1  memory write strobe
- LD_IR  out  1  instruction register load
- LD_AC  out  1  accumulator load
- DATA_E out  1  accumulator drives data bus
- PC_EN  out  1  to counter EN
- PC_LD  out  1  to counter LD (meaningful only with PC_EN)
- HALT   out  1  processor halted

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- State:
  - 3-bit phase register, 0..7, increments every clock and wraps 7 -> 0.
  - 1-bit halted flag.
- Reset:
  - RST high at a rising edge sets phase = INST_ADDR(0) and clears halted, regardless of phase or halted state.
  - While RST is high, outputs are forced to: SEL=1, all others 0.
- Outputs: combinational decode of phase, OPCODE and ZERO, no added latency.
  - ALUOP = OPCODE in {ADD, AND, XOR, LDA}.
  - 0 INST_ADDR:  SEL=1
  - 1 INST_FETCH: SEL=1, RD=1
  - 2 INST_LOAD:  SEL=1, RD=1, LD_IR=1
  - 3 IDLE:       SEL=1, RD=1, LD_IR=1
  - 4 OP_ADDR:    PC_EN=1 (increment), PC_LD=0; HALT=(OPCODE==HLT)
  - 5 OP_FETCH:   RD=ALUOP
  - 6 ALU_OP:     RD=ALUOP; DATA_E=(OPCODE==STO); if OPCODE==JMP then PC_EN=1, PC_LD=1; else if OPCODE==SKZ and ZERO then PC_EN=1, PC_LD=0
  - 7 STORE:      RD=ALUOP, LD_AC=ALUOP, DATA_E=(OPCODE==STO), WR=(OPCODE==STO); if OPCODE==JMP then PC_EN=1, PC_LD=1
  - Unlisted outputs are 0 in each phase.
- Halt:
  - At the edge leaving OP_ADDR with OPCODE==HLT, halted is set and phase freezes at OP_ADDR.
  - While halted: HALT=1, every other output is 0 (PC_EN=0, so PC holds). Only RST exits.
  - The OP_ADDR cycle that decodes HLT still increments the PC, so the halted PC equals the HLT address + 1.
- Invariants:
  - PC_LD=1 implies PC_EN=1.
  - RD and WR are never both 1.
  - WR=1 implies DATA_E=1.
- OPCODE and ZERO are sampled only through the decode; they may change freely in other phases.
- JMP asserts load in both phase 6 and phase 7. The double load of the same IR operand is intended.

Decomposition:
- risc_pkg holds:
  - typedef enum logic [2:0] opcode_t: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
  - typedef enum logic [2:0] phase_t: INST_ADDR .. STORE = 0..7
  - function is_aluop(opcode_t)
- No sub-module. Phase register, halted flag and output decode live in one module.

Test Plan:
- RST=1 for 2 cycles, then release with OPCODE=ADD: outputs SEL=1, others 0 during reset; phase walks 0..7, then wraps to 0; LD_IR=1 in phases 2–3; LD_AC=1 only in phase 7; PC_EN=1 only in phase 4.
- OPCODE=STO over a full cycle: DATA_E=1 in phases 6–7; WR=1 only in phase 7; RD=0 in phases 5–7.
- OPCODE=JMP: PC_EN=PC_LD=1 in phases 6 and 7, PC_EN=1 with PC_LD=0 in phase 4. Counter model loads operand 8'h1A, then next fetch address is 8'h1A.
- OPCODE=SKZ:
  - ZERO=1: PC_EN=1, PC_LD=0 in phase 6, so PC advances 2 per instruction.
  - ZERO=0: no PC_EN in phase 6, so PC advances 1.
- OPCODE=HLT at phase 4: HALT=1 in phase 4, then held for 20 cycles with all other outputs 0. RST=1 for one cycle returns to phase 0 with HALT=0.
- RST asserted in phase 6 with JMP: next cycle phase=0, PC_EN=0 during the reset cycle, and there is no residual WR or LD_AC.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - opcode/phase types and decode helper for the RISC sequencer
//
// Purpose : shared types for the eight-phase sequencer.
//   opcode_t  3-bit instruction opcode from the instruction register
//   phase_t   3-bit sequencer phase, INST_ADDR (0) .. STORE (7)
//   is_aluop  true for opcodes that read memory into the accumulator

package risc_pkg;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  function automatic logic is_aluop(opcode_t op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/risc_sequencer.sv
// rtl/risc_sequencer.sv - eight-phase instruction sequencer for the basic RISC core
//
// Purpose : steps through eight phases per instruction and decodes the
//           opcode and accumulator-zero flag into datapath strobes.
// Ports   :
//   CLK     in  system clock, rising edge
//   RST     in  synchronous reset, active-high
//   OPCODE  in  opcode field from the instruction register
//   ZERO    in  accumulator == 0
//   SEL     out address mux select (1 = PC, 0 = IR operand)
//   RD, WR  out memory read / write strobes
//   LD_IR   out instruction register load
//   LD_AC   out accumulator load
//   DATA_E  out accumulator drives data bus
//   PC_EN   out program counter enable
//   PC_LD   out program counter load (qualified by PC_EN)
//   HALT    out processor halted

module risc_sequencer
  import risc_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  opcode_t OPCODE,
  input  logic    ZERO,
  output logic    SEL,
  output logic    RD,
  output logic    WR,
  output logic    LD_IR,
  output logic    LD_AC,
  output logic    DATA_E,
  output logic    PC_EN,
  output logic    PC_LD,
  output logic    HALT
);

  phase_t phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // Leaving OP_ADDR on HLT sets halted and parks the phase at OP_ADDR.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (phase_q == OP_ADDR && OPCODE == HLT) begin
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(3'(phase_q + 3'd1));
      end
    end
  end

  assign aluop = is_aluop(OPCODE);

  always_comb begin
    SEL    = 1'b0;
    RD     = 1'b0;
    WR     = 1'b0;
    LD_IR  = 1'b0;
    LD_AC  = 1'b0;
    DATA_E = 1'b0;
    PC_EN  = 1'b0;
    PC_LD  = 1'b0;
    HALT   = 1'b0;
    if (RST) begin
      SEL = 1'b1;
    end else if (halted_q) begin
      HALT = 1'b1;
    end else begin
      case (phase_q)
        INST_ADDR: begin
          SEL = 1'b1;
        end
        INST_FETCH: begin
          SEL = 1'b1;
          RD  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          SEL   = 1'b1;
          RD    = 1'b1;
          LD_IR = 1'b1;
        end
        OP_ADDR: begin
          // PC still increments on the HLT decode cycle.
          PC_EN = 1'b1;
          HALT  = (OPCODE == HLT);
        end
        OP_FETCH: begin
          RD = aluop;
        end
        ALU_OP: begin
          RD     = aluop;
          DATA_E = (OPCODE == STO);
          if (OPCODE == JMP) begin
            PC_EN = 1'b1;
            PC_LD = 1'b1;
          end else if (OPCODE == SKZ && ZERO) begin
            PC_EN = 1'b1;
          end
        end
        STORE: begin
          RD     = aluop;
          LD_AC  = aluop;
          DATA_E = (OPCODE == STO);
          WR     = (OPCODE == STO);
          // JMP loads the same operand again; harmless and intended.
          if (OPCODE == JMP) begin
            PC_EN = 1'b1;
            PC_LD = 1'b1;
          end
        end
        default: begin
          SEL = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_risc_sequencer.sv
// tb/tb_risc_sequencer.sv - scoreboard testbench for risc_sequencer

module tb_risc_sequencer;
  import risc_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  opcode_t opcode;
  logic    zero;
  logic    sel, rd, wr, ld_ir, ld_ac, data_e, pc_en, pc_ld, halt;

  risc_sequencer dut (
    .CLK(clk), .RST(rst), .OPCODE(opcode), .ZERO(zero),
    .SEL(sel), .RD(rd), .WR(wr), .LD_IR(ld_ir), .LD_AC(ld_ac),
    .DATA_E(data_e), .PC_EN(pc_en), .PC_LD(pc_ld), .HALT(halt)
  );

  always #5 clk = ~clk;

  // bit order: SEL RD WR LD_IR LD_AC DATA_E PC_EN PC_LD HALT
  localparam logic [8:0] V_RST  = 9'b100000000;
  localparam logic [8:0] V_HALT = 9'b000000001;
  localparam int K_ADD = 0, K_STO = 1, K_JMP = 2, K_SKZ1 = 3, K_SKZ0 = 4, K_HLT = 5;

  logic [8:0] tbl [6][8];

  typedef struct {
    logic [8:0] vec;
    logic       chk_pc;
    logic [7:0] pc;
    int         tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // program counter model fed by the sequencer's PC_EN/PC_LD
  logic [7:0] pc_model = 8'h00;
  logic       en_s = 1'b0, ld_s = 1'b0;
  always @(negedge clk) begin
    en_s <= pc_en;
    ld_s <= pc_ld;
  end
  always @(posedge clk) begin
    if (en_s) pc_model <= ld_s ? 8'h1A : pc_model + 8'd1;
  end

  wire [8:0] outs = {sel, rd, wr, ld_ir, ld_ac, data_e, pc_en, pc_ld, halt};

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (outs !== e.vec) begin
        n_fail++;
        $display("FAIL outs[%0d]: got %b expected %b", e.tag, outs, e.vec);
      end
      if (e.chk_pc) begin
        n_cmp++;
        if (pc_model !== e.pc) begin
          n_fail++;
          $display("FAIL pc[%0d]: got %h expected %h", e.tag, pc_model, e.pc);
        end
      end
    end
  end

  task automatic step(input logic [8:0] v, input logic chk, input logic [7:0] pc);
    exp_t e;
    e.vec = v; e.chk_pc = chk; e.pc = pc; e.tag = cyc;
    sb.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // run phases 0..nph-1 of one instruction; PC checked during phase 0
  task automatic run_instr(input opcode_t op, input logic z, input int k,
                           input int nph, input logic [7:0] pc0);
    opcode = op;
    zero   = z;
    for (int p = 0; p < nph; p++) begin
      step(tbl[k][p], p == 0, pc0);
    end
  endtask

  initial begin
    tbl[K_ADD]  = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000100, 9'b010000000, 9'b010000000, 9'b010010000};
    tbl[K_STO]  = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000100, 9'b000000000, 9'b000001000, 9'b001001000};
    tbl[K_JMP]  = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000100, 9'b000000000, 9'b000000110, 9'b000000110};
    tbl[K_SKZ1] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000100, 9'b000000000, 9'b000000100, 9'b000000000};
    tbl[K_SKZ0] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000100, 9'b000000000, 9'b000000000, 9'b000000000};
    tbl[K_HLT]  = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                    9'b000000101, 9'b000000000, 9'b000000000, 9'b000000000};

    rst = 1'b1; opcode = ADD; zero = 1'b0;
    @(posedge clk);
    #1;
    step(V_RST, 1'b0, 8'h00);
    step(V_RST, 1'b1, 8'h00);
    rst = 1'b0;

    run_instr(ADD, 1'b0, K_ADD,  8, 8'h00);
    run_instr(STO, 1'b1, K_STO,  8, 8'h01);
    run_instr(JMP, 1'b0, K_JMP,  8, 8'h02);
    run_instr(SKZ, 1'b1, K_SKZ1, 8, 8'h1A);
    run_instr(SKZ, 1'b0, K_SKZ0, 8, 8'h1C);
    run_instr(HLT, 1'b0, K_HLT,  5, 8'h1D);

    // halted: opcode may wander, phase and PC stay frozen
    opcode = JMP; zero = 1'b1;
    for (int i = 0; i < 20; i++) step(V_HALT, i == 19, 8'h1E);

    rst = 1'b1;
    step(V_RST, 1'b1, 8'h1E);
    rst = 1'b0;

    // JMP cut short by reset in ALU_OP: no load, no leftover strobes
    run_instr(JMP, 1'b0, K_JMP, 6, 8'h1E);
    rst = 1'b1;
    step(V_RST, 1'b0, 8'h00);
    rst = 1'b0;
    run_instr(ADD, 1'b0, K_ADD, 8, 8'h1F);
    run_instr(LDA, 1'b0, K_ADD, 8, 8'h20);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
